vga_plot_arbiter: RTL
=====================

Name: vga_plot_arbiter

Overview:
Shares the single VGA adapter pixel-write port (x, y, colour, plot) between NREQ rectangle-drawing requesters, such as the tile renderer, score renderer and background eraser inside the game state manager.
- Requesters present a rectangle fill command with a req/ack/done handshake.
- The arbiter grants requesters round-robin and rasterises the granted rectangle at one pixel per clock.
- Off-screen pixels are clipped.
- Its outputs drive the vga_adapter x, y, colour and plot inputs directly.

Parameters:
NREQ, 3, number of requesters
XW, 9, x coordinate / width field bits
YW, 9, y coordinate / height field bits
CW, 9, colour bits (3 per channel)
SCREEN_W, 160, visible columns
SCREEN_H, 120, visible rows
BG_COLOUR, 0, fill colour for the optional clear

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; command must be stable while high and before ack
cmd_x  in  NREQ*XW  packed rectangle left x; requester i uses slice [i*XW +: XW]
cmd_y  in  NREQ*YW  packed top y
cmd_w  in  NREQ*XW  packed width in pixels
cmd_h  in  NREQ*YW  packed height in pixels
cmd_colour  in  NREQ*CW  packed fill colour
ack  out  NREQ  one-cycle pulse: command latched
done  out  NREQ  one-cycle pulse: rectangle complete
busy  out  1  high whenever state is not IDLE
x  out  XW  pixel x to adapter
y  out  YW  pixel y to adapter
colour  out  CW  pixel colour to adapter
draw_en  out  1  plot strobe to adapter

Behaviour:
- Reset (asynchronous, any state, including mid-rectangle):
  - state goes to IDLE; last_grant goes to NREQ-1.
  - ack, done, busy, x, y, colour and draw_en all go to 0.
  - No done is issued for an aborted rectangle; its partially drawn pixels remain on screen.
- All outputs are registered.
- States: IDLE, DRAW, FINISH (plus CLEAR, see Optional Feature).
- IDLE, cycle T, any req high:
  - Pick the first set bit searching from (last_grant+1) mod NREQ upward, wrapping. Call it g.
  - Latch requester g's command, set last_grant=g, clear col=row=0.
  - At T+1: ack[g]=1 for exactly one cycle.
  - Go to DRAW, or to FINISH if w==0 or h==0.
- req is sampled only in IDLE:
  - Dropping req before ack withdraws the request with no effect.
  - After ack, the requester may change its command or drop req.
  - A req still high when the arbiter returns to IDLE is a new request.
- DRAW, each cycle: load the output registers with px=x0+col, py=y0+row, colour=latched colour.
  - draw_en=1 only if px<SCREEN_W and py<SCREEN_H; otherwise draw_en=0 (clipped pixel, cycle still consumed).
  - Sums are computed XW+1 / YW+1 bits wide, so overflow never wraps onto the visible screen.
- Raster order: col increments first. When col==w-1, col=0 and row increments. When row==h-1 and col==w-1, go to FINISH.
- Timing: pixel k (0-based) is visible at T+2+k. The rectangle takes exactly w*h pixel cycles.
- FINISH, one cycle: done[g]=1; the output registers show the last pixel (for an empty rectangle, draw_en=0). Go to IDLE.
  - Non-empty rectangle: done at T+1+w*h.
  - Empty rectangle: ack and done are asserted in the same cycle, T+1.
  - The next request can be sampled in the cycle after FINISH.
- Outside DRAW and FINISH, draw_en=0 and x, y, colour hold their last values.
- At most one ack bit and one done bit are set in any cycle.

Optional Feature:
Macro VGA_ARB_CLEAR_ON_RESET_EN.
- Defined: on leaving reset, the state is CLEAR.
  - Emits every pixel (0,0)..(159,119) in raster order with colour=BG_COLOUR and draw_en=1, one pixel per cycle, SCREEN_W*SCREEN_H cycles in total.
  - busy=1 throughout; req is ignored; no ack or done pulses; then goes to IDLE.
  - The first request can be acked at the earliest 19201 cycles after reset release.
- Undefined: reset enters IDLE directly and the CLEAR logic is absent.

Test Plan:
- req[0] only, x=10, y=20, w=3, h=2, colour=9'h1C0, req seen at T.
  - ack[0] at T+1.
  - draw_en high T+2..T+7 with pixels (10,20), (11,20), (12,20), (10,21), (11,21), (12,21).
  - done[0] at T+7, busy low at T+8.
- All three req held continuously, each w=h=1.
  - Grant order 0,1,2,0,1,2.
  - Each rectangle: one pixel, ack-to-ack spacing 3 cycles, never two ack bits set.
- req[1] with x=158, y=119, w=4, h=2.
  - 8 pixel cycles; draw_en only for (158,119) and (159,119).
  - done[1] 8 cycles after ack.
- req[2] with w=0, h=5.
  - ack[2] and done[2] both high at T+1, draw_en never high.
  - Back in IDLE at T+2.
- Assert resetn low during pixel 3 of a 10x10 rectangle from requester 1.
  - All outputs 0 immediately, no done.
  - After release, with req[0] and req[1] both high, requester 0 is granted first.
- With VGA_ARB_CLEAR_ON_RESET_EN defined:
  - After reset, exactly 19200 draw_en cycles with colour=BG_COLOUR, last pixel (159,119).
  - A req held throughout is acked only after busy falls.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares the single VGA adapter pixel-write port between NREQ rectangle
//   fill requesters. Requesters are granted round-robin. The granted rectangle
//   is rasterised at one pixel per clock, and off-screen pixels are clipped.
//
//   Optional feature (compile-time macro VGA_ARB_CLEAR_ON_RESET_EN): after
//   reset the block first paints the whole visible screen with BG_COLOUR and
//   only then accepts requests.
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   req        per-requester request (command stable while high, until ack)
//   cmd_x/y    packed rectangle top-left corner, requester i at [i*W +: W]
//   cmd_w/h    packed rectangle width / height in pixels
//   cmd_colour packed fill colour
//   ack        one-cycle pulse: command of that requester latched
//   done       one-cycle pulse: rectangle of that requester complete
//   busy       high whenever the FSM is not in IDLE
//   x/y/colour pixel to the adapter
//   draw_en    plot strobe to the adapter
//   state_dbg  current FSM state (0 IDLE, 1 DRAW, 2 FINISH, 3 CLEAR)
//
// Handshake: a requester raises req with a stable command. The arbiter samples
// req only in IDLE and answers the winner with a one-cycle ack. After ack the
// requester may drop req or change its command. A one-cycle done follows when
// the last pixel has been presented. A req still high when the arbiter returns
// to IDLE counts as a new request.
module vga_plot_arbiter #(
    parameter int NREQ      = 3,
    parameter int XW        = 9,
    parameter int YW        = 9,
    parameter int CW        = 9,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int BG_COLOUR = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*XW-1:0]   cmd_x,
    input  logic [NREQ*YW-1:0]   cmd_y,
    input  logic [NREQ*XW-1:0]   cmd_w,
    input  logic [NREQ*YW-1:0]   cmd_h,
    input  logic [NREQ*CW-1:0]   cmd_colour,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [XW-1:0]        x,
    output logic [YW-1:0]        y,
    output logic [CW-1:0]        colour,
    output logic                 draw_en,
    output logic [1:0]           state_dbg
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LAST_REQ = NREQ - 1;
    localparam logic [GW-1:0] LAST_GRANT_RST = LAST_REQ[GW-1:0];
    localparam logic [XW:0]   SW_L  = SCREEN_W[XW:0];
    localparam logic [YW:0]   SH_L  = SCREEN_H[YW:0];
    localparam logic [XW-1:0] X_ONE = 1;
    localparam logic [YW-1:0] Y_ONE = 1;
`ifdef VGA_ARB_CLEAR_ON_RESET_EN
    localparam int SWM1 = SCREEN_W - 1;
    localparam int SHM1 = SCREEN_H - 1;
    localparam logic [XW-1:0] CLR_X_LAST = SWM1[XW-1:0];
    localparam logic [YW-1:0] CLR_Y_LAST = SHM1[YW-1:0];
    localparam logic [CW-1:0] BG         = BG_COLOUR[CW-1:0];
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAW   = 2'd1,
        S_FINISH = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   last_grant, last_grant_n, grant, grant_n;
    logic [XW-1:0]   x0, x0_n, w_r, w_n, col, col_n;
    logic [YW-1:0]   y0, y0_n, h_r, h_n, row, row_n;
    logic [CW-1:0]   fill, fill_n;
    logic [NREQ-1:0] ack_n, done_n;
    logic            busy_n, draw_en_n;
    logic [XW-1:0]   x_n;
    logic [YW-1:0]   y_n;
    logic [CW-1:0]   colour_n;
    logic [XW:0]     px;
    logic [YW:0]     py;
    logic            found;
    logic [GW-1:0]   pick, cand;
    int              idx;

    assign state_dbg = state;

    // Round-robin search starting one past the last grant, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx  = (int'(last_grant) + i) % NREQ;
            cand = idx[GW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        // One bit wider than the coordinate so overflow lands off-screen.
        px = {1'b0, x0} + {1'b0, col};
        py = {1'b0, y0} + {1'b0, row};

        state_n      = state;
        last_grant_n = last_grant;
        grant_n      = grant;
        x0_n         = x0;
        y0_n         = y0;
        w_n          = w_r;
        h_n          = h_r;
        fill_n       = fill;
        col_n        = col;
        row_n        = row;
        ack_n        = '0;
        done_n       = '0;
        draw_en_n    = 1'b0;
        x_n          = x;
        y_n          = y;
        colour_n     = colour;

        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_n      = pick;
                    last_grant_n = pick;
                    x0_n         = cmd_x[pick*XW +: XW];
                    y0_n         = cmd_y[pick*YW +: YW];
                    w_n          = cmd_w[pick*XW +: XW];
                    h_n          = cmd_h[pick*YW +: YW];
                    fill_n       = cmd_colour[pick*CW +: CW];
                    col_n        = '0;
                    row_n        = '0;
                    ack_n[pick]  = 1'b1;
                    // An empty rectangle acks and completes in the same cycle.
                    if (cmd_w[pick*XW +: XW] == '0 || cmd_h[pick*YW +: YW] == '0) begin
                        state_n      = S_FINISH;
                        done_n[pick] = 1'b1;
                    end else begin
                        state_n = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                x_n       = px[XW-1:0];
                y_n       = py[YW-1:0];
                colour_n  = fill;
                draw_en_n = (px < SW_L) && (py < SH_L);
                if (col == w_r - X_ONE) begin
                    col_n = '0;
                    if (row == h_r - Y_ONE) begin
                        // done lines up with the last pixel on the outputs.
                        state_n       = S_FINISH;
                        done_n[grant] = 1'b1;
                    end else begin
                        row_n = row + Y_ONE;
                    end
                end else begin
                    col_n = col + X_ONE;
                end
            end
            S_FINISH: begin
                state_n = S_IDLE;
            end
`ifdef VGA_ARB_CLEAR_ON_RESET_EN
            S_CLEAR: begin
                x_n       = col;
                y_n       = row;
                colour_n  = BG;
                draw_en_n = 1'b1;
                if (col == CLR_X_LAST) begin
                    col_n = '0;
                    if (row == CLR_Y_LAST) begin
                        state_n = S_IDLE;
                    end else begin
                        row_n = row + Y_ONE;
                    end
                end else begin
                    col_n = col + X_ONE;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
`ifdef VGA_ARB_CLEAR_ON_RESET_EN
            state <= S_CLEAR;
            busy  <= 1'b1;
`else
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
            last_grant <= LAST_GRANT_RST;
            grant      <= '0;
            x0         <= '0;
            y0         <= '0;
            w_r        <= '0;
            h_r        <= '0;
            fill       <= '0;
            col        <= '0;
            row        <= '0;
            ack        <= '0;
            done       <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            draw_en    <= 1'b0;
        end else begin
            state      <= state_n;
            busy       <= busy_n;
            last_grant <= last_grant_n;
            grant      <= grant_n;
            x0         <= x0_n;
            y0         <= y0_n;
            w_r        <= w_n;
            h_r        <= h_n;
            fill       <= fill_n;
            col        <= col_n;
            row        <= row_n;
            ack        <= ack_n;
            done       <= done_n;
            x          <= x_n;
            y          <= y_n;
            colour     <= colour_n;
            draw_en    <= draw_en_n;
        end
    end

endmodule
